// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and the alignment-mask helper for the program-counter unit
package pc_pkg;
    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned INC_DEFAULT = 4;
    localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
    function automatic logic [63:0] align_mask(input int unsigned inc);
        return ~(64'(inc) - 64'd1);
    endfunction
endpackage

// File: rtl/pc_delay_line.sv
// pc_delay_line: valid-tagged shift register aligning the fetch PC with later stages
module pc_delay_line #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DELAY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic            flush,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            dout_valid
);
    for (genvar s = 0; s < DELAY; s++) begin : g_stage
        logic [XLEN-1:0] data_q;
        logic            valid_q;
        logic [XLEN-1:0] src;
        logic            src_v;
        if (s == 0) begin : g_head
            assign src = din;
            assign src_v = 1'b1;
        end else begin : g_body
            assign src = g_stage[s-1].data_q;
            assign src_v = g_stage[s-1].valid_q;
        end
        // a flush only clears the tags; stale data is harmless once invalid
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
                valid_q <= 1'b0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q <= src;
                valid_q <= src_v;
            end
        end
    end
    assign dout = g_stage[DELAY-1].data_q;
    assign dout_valid = g_stage[DELAY-1].valid_q;
endmodule

// File: rtl/pc_pipeline.sv
// pc_pipeline: fetch PC register with stall, redirect/flush, misalignment pulse and delayed PC
module pc_pipeline
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int unsigned INC = INC_DEFAULT,
    parameter int unsigned DELAY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_d,
    output logic            pc_d_valid,
    output logic            misaligned
);
    localparam logic [63:0] FULL_MASK = align_mask(INC);
    localparam logic [XLEN-1:0] MASK = FULL_MASK[XLEN-1:0];
    localparam logic [XLEN-1:0] STEP = XLEN'(INC);
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic            mis_q, mis_d;
    logic            advance;
    assign advance = !redirect_valid && !stall;
    always_comb begin
        pc_f_d = redirect_valid ? (redirect_target & MASK) : stall ? pc_f_q : pc_f_q + STEP;
        mis_d = redirect_valid && |(redirect_target & ~MASK);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            pc_f_q <= pc_f_d;
            mis_q <= mis_d;
        end
    end
    pc_delay_line #(.XLEN(XLEN), .DELAY(DELAY)) u_delay (
        .clk(clk),
        .reset(reset),
        .advance(advance),
        .flush(redirect_valid),
        .din(pc_f_q),
        .dout(pc_d),
        .dout_valid(pc_d_valid)
    );
    assign pc_f = pc_f_q;
    assign misaligned = mis_q;
endmodule

// File: tb/tb_pc_pipeline.sv
// tb_pc_pipeline: randomized scoreboard bench against a queue-based PC history model
module tb_pc_pipeline;
    localparam int DELAY = 2;
    localparam logic [31:0] INC = 32'd4;
    localparam logic [31:0] RV = 32'h0;
    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic        valid;
        logic        mis;
        logic        chk_pcd;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_f, pc_d;
    logic        pc_d_valid, misaligned;
    exp_t        sb[$];
    int          vectors = 0;
    int          errors = 0;
    logic [31:0] m_pcf = '0;
    logic [31:0] hist[$];
    logic        m_mis = 1'b0;
    logic        m_clean = 1'b1;
    pc_pipeline #(.XLEN(32), .RESET_VECTOR(RV), .INC(4), .DELAY(DELAY)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .pc_f(pc_f),
        .pc_d(pc_d),
        .pc_d_valid(pc_d_valid),
        .misaligned(misaligned)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    // history of PCs that entered the delay line since the last flush/reset
    task automatic cyc(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        #1;
        reset = r;
        stall = st;
        redirect_valid = rv;
        redirect_target = tgt;
        if (r) begin
            m_pcf = RV;
            hist.delete();
            m_clean = 1'b1;
            m_mis = 1'b0;
        end else if (rv) begin
            m_pcf = tgt - (tgt % INC);
            hist.delete();
            m_clean = 1'b0;
            m_mis = (tgt % INC) != 0;
        end else if (st) begin
            m_mis = 1'b0;
        end else begin
            hist.push_back(m_pcf);
            if (hist.size() > DELAY) void'(hist.pop_front());
            m_pcf = m_pcf + INC;
            m_mis = 1'b0;
        end
        e.pc_f = m_pcf;
        e.valid = hist.size() == DELAY;
        e.pc_d = e.valid ? hist[0] : 32'h0;
        e.chk_pcd = e.valid || m_clean;
        e.mis = m_mis;
        sb.push_back(e);
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            chk("pc_f", pc_f, e.pc_f);
            chk("pc_d_valid", {31'b0, pc_d_valid}, {31'b0, e.valid});
            chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            if (e.chk_pcd) chk("pc_d", pc_d, e.pc_d);
        end
    end
    initial begin
        logic [31:0] t;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h200);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h103);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h44);
        cyc(1, 1, 1, 32'h80);
        repeat (3) cyc(0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
        end
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
